// File: rtl/adsr_poly_if.sv
// Envelope bus: shared rates/levels, per-voice note events, per-voice CV out.
interface adsr_poly_if #(
  parameter int WIDTH  = 16,
  parameter int VOICES = 4
);
  logic                      tick;
  logic [VOICES-1:0]         note_on;
  logic [VOICES-1:0]         note_off;
  logic [WIDTH-1:0]          attack_rate;
  logic [WIDTH-1:0]          decay_rate;
  logic [WIDTH-1:0]          sustain_level;
  logic [WIDTH-1:0]          release_rate;
  logic [VOICES*WIDTH-1:0]   cv;
  logic [VOICES-1:0]         active;

  modport master (
    output tick, note_on, note_off,
    output attack_rate, decay_rate,
    output sustain_level, release_rate,
    input  cv, active
  );

  modport slave (
    input  tick, note_on, note_off,
    input  attack_rate, decay_rate,
    input  sustain_level, release_rate,
    output cv, active
  );
endinterface

// File: rtl/adsr_poly.sv
// Polyphonic ADSR envelope, one independent FSM per voice on a shared tick.
// ADSR_EXP_RELEASE_EN selects exponential release (step = max(cv>>EXP_SHIFT,1)).
module adsr_poly #(
  parameter int WIDTH     = 16,
  parameter int VOICES    = 4,
  parameter int EXP_SHIFT = 6
) (
  input logic        clk,
  input logic        rst_n,
  adsr_poly_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    ATTACK,
    DECAY,
    SUSTAIN,
    RELEASE
  } state_e;

  localparam logic [WIDTH-1:0] CvMax = '1;
  localparam logic [WIDTH-1:0] One   = {{(WIDTH-1){1'b0}}, 1'b1};

  // Shift amount only shapes the curve when exponential release is built.
  if (EXP_SHIFT >= WIDTH) begin : g_shift_saturates
  end

  for (genvar v = 0; v < VOICES; v++) begin : g_voice
    state_e           st_q, st_d;
    logic [WIDTH-1:0] cv_q, cv_d;
    logic             on, off_ok, step;
    logic [WIDTH:0]   att_sum, dec_diff;
    logic [WIDTH-1:0] rel_step;
    logic             att_top, dec_hit, rel_hit;

    assign on      = bus.note_on[v];
    assign off_ok  = bus.note_off[v] &&
                     (st_q inside {ATTACK, DECAY, SUSTAIN});
    assign step    = bus.tick && !on && !off_ok;

    assign att_sum = {1'b0, cv_q} + {1'b0, bus.attack_rate};
    assign att_top = att_sum >= {1'b0, CvMax};

    // Borrow out of the extra bit means cv dropped below zero.
    assign dec_diff = {1'b0, cv_q} - {1'b0, bus.decay_rate};
    assign dec_hit  = dec_diff[WIDTH] ||
                      (dec_diff[WIDTH-1:0] <= bus.sustain_level);

`ifdef ADSR_EXP_RELEASE_EN
    logic [WIDTH-1:0] shr;
    assign shr      = cv_q >> EXP_SHIFT;
    assign rel_step = (shr == '0) ? One : shr;
`else
    assign rel_step = bus.release_rate;
`endif
    assign rel_hit = rel_step >= cv_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        st_q <= IDLE;
        cv_q <= '0;
      end else begin
        st_q <= st_d;
        cv_q <= cv_d;
      end
    end

    always_comb begin
      st_d = st_q;
      if (on) begin
        st_d = ATTACK;
      end else if (off_ok) begin
        st_d = RELEASE;
      end else if (step) begin
        case (st_q)
          ATTACK:  if (att_top) st_d = DECAY;
          DECAY:   if (dec_hit) st_d = SUSTAIN;
          RELEASE: if (rel_hit) st_d = IDLE;
          default: st_d = st_q;
        endcase
      end
    end

    always_comb begin
      cv_d = cv_q;
      if (step) begin
        case (st_q)
          IDLE:    cv_d = '0;
          ATTACK:  cv_d = att_top ? CvMax
                                  : att_sum[WIDTH-1:0];
          DECAY:   cv_d = dec_hit ? bus.sustain_level
                                  : dec_diff[WIDTH-1:0];
          SUSTAIN: cv_d = bus.sustain_level;
          RELEASE: cv_d = rel_hit ? '0
                                  : cv_q - rel_step;
          default: cv_d = cv_q;
        endcase
      end
    end

    assign bus.cv[v*WIDTH +: WIDTH] = cv_q;
    assign bus.active[v]            = (st_q != IDLE);
  end

endmodule

// File: doc/adsr_poly.md
# adsr_poly

Parametrised polyphonic ADSR envelope generator for the methane synth voice path. Holds one independent attack/decay/sustain/release state machine per voice. Each machine advances on a shared sample-rate tick and produces a WIDTH-bit control voltage per voice. It replaces the single-voice envelope behind `debug_note_on`, `debug_note_off` and `debug_adsr_cv` in `Top`, and adds per-voice gating, a sustain level that tracks changes live, and an optional exponential release.

## Interface
- `WIDTH`, 16: CV and rate width in bits.
- `VOICES`, 4: number of independent envelopes.
- `EXP_SHIFT`, 6: release curvature shift; used only when `ADSR_EXP_RELEASE_EN` is defined.
- `clk` in 1: system clock, 50 MHz.
- `rst_n` in 1: asynchronous, active-low reset.
- `tick` in 1: one-cycle sample-rate strobe; envelopes step only on this strobe.
- `note_on` in VOICES: per-voice one-cycle trigger.
- `note_off` in VOICES: per-voice one-cycle release.
- `attack_rate` in WIDTH: increment per tick in ATTACK.
- `decay_rate` in WIDTH: decrement per tick in DECAY.
- `sustain_level` in WIDTH: sustain target.
- `release_rate` in WIDTH: decrement per tick in RELEASE (linear mode).
- `cv` out VOICES*WIDTH: registered envelope outputs; voice i occupies `[i*WIDTH +: WIDTH]`.
- `active` out VOICES: voice i state is not IDLE.

## Operation
- States per voice: IDLE, ATTACK, DECAY, SUSTAIN, RELEASE.
- Rate and level inputs are shared by all voices and sampled live every cycle.
- Events are sampled every cycle, whether or not `tick` is high:
  - `note_on[i]` from any state goes to ATTACK. `cv` keeps its current value (retrigger without a click).
  - `note_off[i]` from ATTACK, DECAY or SUSTAIN goes to RELEASE.
  - `note_off[i]` in IDLE or RELEASE is ignored.
  - `note_on[i]` and `note_off[i]` in the same cycle: `note_on` wins.
- On `tick`, with no event for that voice in the same cycle:
  - ATTACK: `cv += attack_rate`, computed with one extra bit. If the result is ≥ 2^WIDTH−1, `cv` is set to 2^WIDTH−1 and the voice goes to DECAY.
  - DECAY: if `cv − decay_rate` ≤ `sustain_level` (including underflow), `cv` is set to `sustain_level` and the voice goes to SUSTAIN. Otherwise `cv` is decremented.
  - SUSTAIN: `cv` is set to `sustain_level` every tick, so a changed level is followed.
  - RELEASE (linear): if `release_rate` ≥ `cv`, `cv` is set to 0 and the voice goes to IDLE. Otherwise `cv −= release_rate`.
  - IDLE: `cv` holds at 0.
- A rate of 0 parks the voice in its current state. This is legal; no timeout.
- Voices never interact, and simultaneous events on different voices are all honoured.

## Timing
- Reset (asynchronous assert, synchronous deassert at the `clk` edge): all states IDLE, all `cv` = 0, `active` = 0.
- Reset mid-envelope: outputs clear immediately, without waiting for a clock edge.
- Event to state/`active` change: 1 cycle. `active` rises on the edge after `note_on`.
- `tick` to `cv` update: 1 cycle. `cv` is stable between ticks.
- An event coinciding with `tick` does the transition only; the arithmetic step is taken on the next tick.
- Throughput: one step per voice per tick. `tick` may be asserted every cycle.

## Configuration
- `ADSR_EXP_RELEASE_EN` defined: the RELEASE step is max(`cv` >> `EXP_SHIFT`, 1), and `release_rate` is ignored. The voice reaches 0 and goes to IDLE when the step is ≥ `cv`.
- Not defined: linear release as specified above, and `EXP_SHIFT` is unused.
- All other behaviour is identical in both builds.

## Test plan
All scenarios use WIDTH=16, VOICES=4, `attack_rate`=0x1000, `decay_rate`=0x0800, `sustain_level`=0x8000, `release_rate`=0x0400, and `tick` every 4 cycles.

- Full envelope on voice 0: `note_on[0]` → `cv[0]` reaches 0xFFFF on tick 16 and enters DECAY. It reaches 0x8000 on the 16th decay tick and holds in SUSTAIN. `note_off[0]` → `cv[0]` reaches 0 after 32 release ticks, `active[0]`=0, and the other voices stay at 0.
- Retrigger: `note_on[1]` while in RELEASE at 0x4000 → ATTACK resumes from 0x4000 and reaches 0xFFFF after 12 ticks.
- Simultaneous events: `note_on[2]` and `note_off[2]` in the same cycle from IDLE → `active[2]`=1 next cycle, state ATTACK. `note_off[3]` in IDLE → no change.
- Live sustain: in SUSTAIN, change `sustain_level` to 0x2000 → `cv` = 0x2000 at the next tick.
- Reset: assert `rst_n`=0 mid-attack with voices 0–3 active → `cv`=0 and `active`=0 immediately, without a clock edge. After release, the block is idle until a `note_on`.
- With `ADSR_EXP_RELEASE_EN` and EXP_SHIFT=6: release from 0x8000 → first step 0x200, so `cv`=0x7E00. `cv` decreases monotonically, the step bottoms out at 1, and the voice reaches IDLE.
